// File: rtl/branch_target_predictor_pkg.sv
// Shared types and constants for the IF-stage branch target predictor.
// Purpose: defines the BTB entry record, the counter reset/allocation
// constants and the saturating 2-bit counter step used when training.
// Ports: none (package).
package branch_target_predictor_pkg;

  // Counter value every entry holds after reset (weakly not-taken).
  localparam logic [1:0] BTB_CTR_INIT    = 2'b01;
  // Counter value given to a freshly allocated taken branch (weakly taken).
  localparam logic [1:0] BTB_CTR_ALLOC_T = 2'b10;
  // Counter value written with jump entries (strongly taken).
  localparam logic [1:0] BTB_CTR_JUMP    = 2'b11;

  // One BTB line. The tag field holds pc >> (IDX_BITS+2), so its upper bits
  // stay zero; keeping it 32 bits wide lets the struct live in this package
  // independently of the index width chosen by the instantiating module.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic        isJump;
    logic [1:0]  ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    32'h0,
    target: 32'h0,
    isJump: 1'b0,
    ctr:    BTB_CTR_INIT
  };

  // Move a 2-bit counter one step toward taken or not-taken, holding at
  // either end instead of wrapping.
  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken) begin
      if (ctr != 2'b11) result = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) result = ctr - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up-counter used for the predictor statistics.
// Purpose: counts qualifying cycles and holds at all-ones instead of wrapping.
// Ports:
//   clk_i  clock
//   clr_i  synchronous clear (dominates inc_i)
//   inc_i  add one this cycle
//   q_o    current count
module sat_counter
  import branch_target_predictor_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step by one unless already at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register; clear wins over any increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q_o = count_q;

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with per-entry 2-bit counters.
// Purpose: zero-latency lookup of the fetch PC producing a taken prediction
// and next-PC, trained by resolved outcomes coming back from EX, plus
// saturating lookup/hit/mispredict statistics.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   if_valid_i, if_pc_i     fetch qualifier and fetch PC
//   prediction_o            predict taken/redirect for if_pc_i
//   pred_target_o           predicted next PC (BTB target or if_pc_i+4)
//   ex_valid_i, ex_pc_i     resolve strobe and PC of the resolved instruction
//   ex_is_branch_i          resolved instruction is a conditional branch
//   ex_is_jump_i            resolved instruction is jal/jalr
//   ex_br_en_i              branch outcome (1 = taken)
//   ex_target_i             resolved target
//   load_btb_i              checker requests a BTB write
//   misprediction_i         checker flagged a mispredict
//   stat_lookups_o          count of if_valid_i cycles
//   stat_hits_o             count of if_valid_i cycles predicting taken
//   stat_mispred_o          count of ex_valid_i & misprediction_i cycles
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_pc_i,
  output logic             prediction_o,
  output logic [31:0]      pred_target_o,
  input  logic             ex_valid_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_is_jump_i,
  input  logic             ex_br_en_i,
  input  logic [31:0]      ex_target_i,
  input  logic             load_btb_i,
  input  logic             misprediction_i,
  output logic [CNT_W-1:0] stat_lookups_o,
  output logic [CNT_W-1:0] stat_hits_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  localparam int NUM_ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_SHIFT   = IDX_BITS + 2;

  btb_entry_t entries_q [NUM_ENTRIES];

  logic [IDX_BITS-1:0] ifIdx;
  logic [IDX_BITS-1:0] exIdx;
  logic [31:0]         ifTag;
  logic [31:0]         exTag;
  btb_entry_t          ifEntry;
  btb_entry_t          exEntry;
  logic                ifHit;
  logic                exHit;
  logic [31:0]         pcPlus4;

  logic                wrEn;
  btb_entry_t          wrEntry;
  logic [1:0]          ctrNext;

  assign ifIdx   = if_pc_i[IDX_BITS+1:2];
  assign exIdx   = ex_pc_i[IDX_BITS+1:2];
  assign ifTag   = if_pc_i >> TAG_SHIFT;
  assign exTag   = ex_pc_i >> TAG_SHIFT;
  assign ifEntry = entries_q[ifIdx];
  assign exEntry = entries_q[exIdx];
  assign ifHit   = ifEntry.valid && (ifEntry.tag == ifTag);
  assign exHit   = exEntry.valid && (exEntry.tag == exTag);
  assign pcPlus4 = if_pc_i + 32'd4;

  // Fetch-side lookup reads the registered table directly, so a write landing
  // this cycle is only seen next cycle. Reset forces a not-taken prediction
  // even though the table contents are being cleared on the same edge.
  always_comb begin
    prediction_o  = 1'b0;
    pred_target_o = pcPlus4;
    if (!rst_i && ifHit && (ifEntry.isJump || ifEntry.ctr[1])) begin
      prediction_o  = 1'b1;
      pred_target_o = ifEntry.target;
    end
  end

  // Training decision for the resolved instruction. Taken branches with a
  // write request (re)allocate the line; a hit keeps counter history, a miss
  // starts weakly taken. Other branch hits only move the counter, and
  // not-taken misses leave the table alone. Jumps need load_btb_i to write.
  always_comb begin
    wrEn    = 1'b0;
    wrEntry = exEntry;
    ctrNext = ctrStep(exEntry.ctr, ex_br_en_i);
    if (ex_valid_i) begin
      if (ex_is_branch_i) begin
        if (load_btb_i && ex_br_en_i) begin
          wrEn           = 1'b1;
          wrEntry.valid  = 1'b1;
          wrEntry.tag    = exTag;
          wrEntry.target = ex_target_i;
          wrEntry.isJump = 1'b0;
          wrEntry.ctr    = exHit ? ctrNext : BTB_CTR_ALLOC_T;
        end else if (exHit) begin
          wrEn        = 1'b1;
          wrEntry.ctr = ctrNext;
        end
      end else if (ex_is_jump_i && load_btb_i) begin
        wrEn           = 1'b1;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = exTag;
        wrEntry.target = ex_target_i;
        wrEntry.isJump = 1'b1;
        wrEntry.ctr    = BTB_CTR_JUMP;
      end
    end
  end

  // Table storage with its single write port; reset drops any pending write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= BTB_ENTRY_RESET;
      end
    end else if (wrEn) begin
      entries_q[exIdx] <= wrEntry;
    end
  end

  // Statistics counters; reset clears them and suppresses counting.
  sat_counter #(.W(CNT_W)) uLookups (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (if_valid_i),
    .q_o   (stat_lookups_o)
  );

  sat_counter #(.W(CNT_W)) uHits (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (if_valid_i && prediction_o),
    .q_o   (stat_hits_o)
  );

  sat_counter #(.W(CNT_W)) uMispred (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (ex_valid_i && misprediction_i),
    .q_o   (stat_mispred_o)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed, table-driven bench for branch_target_predictor (IDX_BITS=6).
// A second instance with 2-bit statistics shares the stimulus so the
// saturation ceiling can be reached in a handful of cycles.
module tb_branch_target_predictor;

  typedef struct {
    logic        ifValid;
    logic [31:0] ifPc;
    logic        exValid;
    logic [31:0] exPc;
    logic        isBranch;
    logic        isJump;
    logic        brEn;
    logic [31:0] target;
    logic        loadBtb;
    logic        mispred;
    logic        expPred;
    logic [31:0] expTarget;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ifValid;
  logic [31:0] ifPc;
  logic        exValid;
  logic [31:0] exPc;
  logic        exIsBranch;
  logic        exIsJump;
  logic        exBrEn;
  logic [31:0] exTarget;
  logic        loadBtb;
  logic        misprediction;

  logic        prediction;
  logic [31:0] predTarget;
  logic [31:0] statLookups;
  logic [31:0] statHits;
  logic [31:0] statMispred;

  logic        satPrediction;
  logic [31:0] satPredTarget;
  logic [1:0]  satLookups;
  logic [1:0]  satHits;
  logic [1:0]  satMispred;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  branch_target_predictor #(.IDX_BITS(6), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_valid_i      (ifValid),
    .if_pc_i         (ifPc),
    .prediction_o    (prediction),
    .pred_target_o   (predTarget),
    .ex_valid_i      (exValid),
    .ex_pc_i         (exPc),
    .ex_is_branch_i  (exIsBranch),
    .ex_is_jump_i    (exIsJump),
    .ex_br_en_i      (exBrEn),
    .ex_target_i     (exTarget),
    .load_btb_i      (loadBtb),
    .misprediction_i (misprediction),
    .stat_lookups_o  (statLookups),
    .stat_hits_o     (statHits),
    .stat_mispred_o  (statMispred)
  );

  branch_target_predictor #(.IDX_BITS(6), .CNT_W(2)) dutSat (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_valid_i      (ifValid),
    .if_pc_i         (ifPc),
    .prediction_o    (satPrediction),
    .pred_target_o   (satPredTarget),
    .ex_valid_i      (exValid),
    .ex_pc_i         (exPc),
    .ex_is_branch_i  (exIsBranch),
    .ex_is_jump_i    (exIsJump),
    .ex_br_en_i      (exBrEn),
    .ex_target_i     (exTarget),
    .load_btb_i      (loadBtb),
    .misprediction_i (misprediction),
    .stat_lookups_o  (satLookups),
    .stat_hits_o     (satHits),
    .stat_mispred_o  (satMispred)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic ifv, input logic [31:0] ifpc,
    input logic exv, input logic [31:0] expc,
    input logic br, input logic jmp, input logic bren,
    input logic [31:0] tgt, input logic load, input logic misp,
    input logic ePred, input logic [31:0] eTgt);
    vec_t v;
    v.ifValid   = ifv;
    v.ifPc      = ifpc;
    v.exValid   = exv;
    v.exPc      = expc;
    v.isBranch  = br;
    v.isJump    = jmp;
    v.brEn      = bren;
    v.target    = tgt;
    v.loadBtb   = load;
    v.mispred   = misp;
    v.expPred   = ePred;
    v.expTarget = eTgt;
    return v;
  endfunction

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input vec_t v);
    ifValid       = v.ifValid;
    ifPc          = v.ifPc;
    exValid       = v.exValid;
    exPc          = v.exPc;
    exIsBranch    = v.isBranch;
    exIsJump      = v.isJump;
    exBrEn        = v.brEn;
    exTarget      = v.target;
    loadBtb       = v.loadBtb;
    misprediction = v.mispred;
  endtask

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(mkVec(0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h4));
  endtask

  task automatic checkStats(input string tag, input int lk, input int ht, input int mp);
    checkOutput({tag, ".lookups"},     statLookups, 32'(lk));
    checkOutput({tag, ".hits"},        statHits,    32'(ht));
    checkOutput({tag, ".mispred"},     statMispred, 32'(mp));
    checkOutput({tag, ".satLookups"},  32'(satLookups),  32'((lk > 3) ? 3 : lk));
    checkOutput({tag, ".satHits"},     32'(satHits),     32'((ht > 3) ? 3 : ht));
    checkOutput({tag, ".satMispred"},  32'(satMispred),  32'((mp > 3) ? 3 : mp));
  endtask

  // Main sequence: reset, table-driven training/lookup vectors, then the
  // mid-stream reset and statistics saturation sequences.
  initial begin
    int expLookups;
    int expHits;
    int expMispred;
    vec_t v;

    rst = 1'b1;
    idleInputs();

    // Vectors: lookup is checked before the edge that commits the update.
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h200, 1, 1, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h200));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0,   0, 1, 1, 32'h200));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h200));
    vecs.push_back(mkVec(1, 32'h200, 1, 32'h200, 1, 0, 0, 32'h0,   0, 0, 0, 32'h204));
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h200));
    vecs.push_back(mkVec(1, 32'h40,  1, 32'h40,  0, 1, 0, 32'h80,  1, 1, 0, 32'h44));
    vecs.push_back(mkVec(1, 32'h40,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h80));
    vecs.push_back(mkVec(0, 32'h40,  1, 32'h40,  0, 1, 0, 32'hC0,  0, 0, 1, 32'h80));
    vecs.push_back(mkVec(1, 32'h80,  1, 32'h80,  0, 0, 1, 32'h300, 1, 0, 0, 32'h84));
    vecs.push_back(mkVec(0, 32'h80,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h84));
    vecs.push_back(mkVec(1, 32'h80,  0, 32'h80,  1, 0, 1, 32'h400, 1, 1, 0, 32'h84));
    vecs.push_back(mkVec(1, 32'h80,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h84));
    vecs.push_back(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h500, 1, 0, 1, 32'h200));
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h500));
    vecs.push_back(mkVec(1, 32'h200, 1, 32'h200, 1, 0, 1, 32'h600, 1, 1, 0, 32'h204));
    vecs.push_back(mkVec(1, 32'h200, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h600));
    vecs.push_back(mkVec(1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h104));
    vecs.push_back(mkVec(1, 32'h200, 1, 32'h200, 1, 0, 0, 32'h0,   0, 1, 1, 32'h600));
    vecs.push_back(mkVec(1, 32'h200, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h204));
    vecs.push_back(mkVec(1, 32'h40,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 1, 32'h80));

    // Lookup during reset must not predict.
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(mkVec(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h200, 1, 1, 0, 32'h104));
    @(negedge clk);
    checkOutput("reset.pred",   32'(prediction), 32'h0);
    checkOutput("reset.target", predTarget,      32'h104);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    checkStats("afterReset", 0, 0, 0);

    expLookups = 0;
    expHits    = 0;
    expMispred = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.pred", i),   32'(prediction), 32'(v.expPred));
      checkOutput($sformatf("vec%0d.target", i), predTarget,      v.expTarget);
      if (v.ifValid) expLookups++;
      if (v.ifValid && v.expPred) expHits++;
      if (v.exValid && v.mispred) expMispred++;
      @(posedge clk);
      #1;
    end
    idleInputs();
    @(negedge clk);
    checkStats("table", expLookups, expHits, expMispred);

    // Reset asserted while an update is presented: lookup still blocked,
    // update discarded, everything cleared.
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(mkVec(1, 32'h40, 1, 32'h80, 0, 1, 0, 32'h300, 1, 1, 0, 32'h44));
    @(negedge clk);
    checkOutput("midReset.pred",   32'(prediction), 32'h0);
    checkOutput("midReset.target", predTarget,      32'h44);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    checkStats("midReset", 0, 0, 0);
    foreach (vecs[i]) begin
      if (i < 3) begin
        logic [31:0] pc;
        pc = (i == 0) ? 32'h40 : (i == 1) ? 32'h200 : 32'h80;
        ifPc = pc;
        #1;
        checkOutput($sformatf("postReset.pred%0d", i),   32'(prediction), 32'h0);
        checkOutput($sformatf("postReset.target%0d", i), predTarget,      pc + 32'd4);
      end
    end

    // Install a jump, then hit on it repeatedly with mispredict strobes so
    // the 2-bit statistics reach their ceiling.
    @(posedge clk);
    #1;
    applyStimulus(mkVec(0, 32'h0, 1, 32'h40, 0, 1, 0, 32'h80, 1, 0, 0, 32'h4));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(mkVec(1, 32'h40, 1, 32'h1000, 0, 0, 0, 32'h0, 0, 1, 1, 32'h80));
      @(negedge clk);
      checkOutput($sformatf("sat%0d.pred", k), 32'(prediction), 32'h1);
    end
    @(posedge clk);
    #1;
    idleInputs();
    @(negedge clk);
    checkStats("saturate", 5, 5, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
